// File: rtl/prog_sequencer.sv
// prog_sequencer: executes a bit-logic program for the scan controller's PROG phase.
// Completion is signalled by driving all-ones on A_0, A_1 and A_2 together.
module prog_sequencer #(
  parameter int BIP_W = 12,
  parameter int WIP_W = 16
) (
  input  logic             CLK,
  input  logic             CLR,
  input  logic             START,
  input  logic [15:0]      PROG_DATA,
  input  logic             IN_BIT,
  output logic [BIP_W-1:0] A_0,
  output logic [WIP_W-1:0] A_1,
  output logic [BIP_W-1:0] A_2,
  output logic             OUT_BIT,
  output logic             OUT_WE,
  output logic             ACC,
  output logic             BUSY
);
  typedef enum logic [2:0] {IDLE, FETCH, EXEC, RD_WAIT, RD_CAP, FIN} state_t;

  localparam logic [3:0] OP_LD  = 4'h1;
  localparam logic [3:0] OP_AND = 4'h2;
  localparam logic [3:0] OP_OR  = 4'h3;
  localparam logic [3:0] OP_XOR = 4'h4;
  localparam logic [3:0] OP_NOT = 4'h5;
  localparam logic [3:0] OP_ST  = 4'h6;
  localparam logic [3:0] OP_END = 4'hF;

  state_t           state_reg, state_next;
  logic [BIP_W-1:0] a_0_reg, a_0_next, a_2_reg, a_2_next;
  logic [WIP_W-1:0] a_1_reg, a_1_next, pc_inc;
  logic             out_bit_reg, out_bit_next;
  logic             out_we_reg, out_we_next;
  logic             acc_reg, acc_next;
  logic [3:0]       op_reg, op_next;
  logic [3:0]       opcode;
  logic [BIP_W-1:0] operand;

  assign opcode  = PROG_DATA[15:12];
  assign operand = PROG_DATA[BIP_W-1:0];
  assign pc_inc  = a_1_reg + WIP_W'(1);

  always_ff @(posedge CLK) begin
    if (CLR) begin
      state_reg   <= IDLE;
      a_0_reg     <= '0;
      a_1_reg     <= '0;
      a_2_reg     <= '0;
      out_bit_reg <= 1'b0;
      out_we_reg  <= 1'b0;
      acc_reg     <= 1'b0;
      op_reg      <= '0;
    end else begin
      state_reg   <= state_next;
      a_0_reg     <= a_0_next;
      a_1_reg     <= a_1_next;
      a_2_reg     <= a_2_next;
      out_bit_reg <= out_bit_next;
      out_we_reg  <= out_we_next;
      acc_reg     <= acc_next;
      op_reg      <= op_next;
    end
  end

  always_comb begin
    state_next   = state_reg;
    a_0_next     = a_0_reg;
    a_1_next     = a_1_reg;
    a_2_next     = a_2_reg;
    out_bit_next = out_bit_reg;
    out_we_next  = 1'b0;
    acc_next     = acc_reg;
    op_next      = op_reg;

    case (state_reg)
      IDLE: begin
        a_0_next = '0;
        a_1_next = '0;
        a_2_next = '0;
        acc_next = 1'b0;
        if (START) state_next = FETCH;
      end
      FETCH: state_next = EXEC;
      EXEC: begin
        op_next = opcode;
        case (opcode)
          OP_LD, OP_AND, OP_OR, OP_XOR: begin
            a_0_next   = operand;
            state_next = RD_WAIT;
          end
          OP_ST: begin
            a_2_next     = operand;
            out_bit_next = acc_reg;
            out_we_next  = 1'b1;
            state_next   = FETCH;
          end
          OP_NOT: begin
            acc_next   = ~acc_reg;
            state_next = FETCH;
          end
          OP_END: begin
            a_0_next   = '1;
            a_1_next   = '1;
            a_2_next   = '1;
            state_next = FIN;
          end
          default: state_next = FETCH;
        endcase
        if (opcode != OP_END) begin
          a_1_next = pc_inc;
          // Reaching the last word ends the program; any write from this word is dropped
          // so the all-ones completion pattern is never mistaken for a store.
          if (pc_inc == '1) begin
            a_0_next    = '1;
            a_2_next    = '1;
            out_we_next = 1'b0;
            state_next  = FIN;
          end
        end
      end
      RD_WAIT: state_next = RD_CAP;
      RD_CAP: begin
        case (op_reg)
          OP_LD:   acc_next = IN_BIT;
          OP_AND:  acc_next = acc_reg & IN_BIT;
          OP_OR:   acc_next = acc_reg | IN_BIT;
          OP_XOR:  acc_next = acc_reg ^ IN_BIT;
          default: acc_next = acc_reg;
        endcase
        state_next = FETCH;
      end
      FIN: ;
      default: state_next = IDLE;
    endcase

    // Dropping START anywhere outside IDLE aborts (or leaves FIN) and clears the addresses.
    if (state_reg != IDLE && !START) begin
      state_next  = IDLE;
      a_0_next    = '0;
      a_1_next    = '0;
      a_2_next    = '0;
      acc_next    = 1'b0;
      out_we_next = 1'b0;
    end
  end

  assign A_0     = a_0_reg;
  assign A_1     = a_1_reg;
  assign A_2     = a_2_reg;
  assign OUT_BIT = out_bit_reg;
  assign OUT_WE  = out_we_reg;
  assign ACC     = acc_reg;
  assign BUSY    = (state_reg != IDLE);
endmodule
